// File: rtl/cbus_ram_responder.sv
// Cache-bus RAM responder: serves FIXED/INCR/WRAP bursts from an on-chip 64-bit word array.
// Optional CBUS_RAM_STALL_EN inserts LFSR-driven (x^16+x^14+x^13+x^11+1, seed 16'hACE1) beat stalls.
package cbus_pkg;
  localparam int unsigned CBUS_AW = 32;
  localparam int unsigned CBUS_DW = 64;
  localparam int unsigned CBUS_SW = CBUS_DW / 8;

  localparam logic [2:0] MSIZE8 = 3'd3;
  localparam logic [7:0] MLEN1  = 8'd0;
  localparam logic [7:0] MLEN2  = 8'd1;
  localparam logic [7:0] MLEN4  = 8'd3;
  localparam logic [7:0] MLEN8  = 8'd7;
  localparam logic [7:0] MLEN16 = 8'd15;

  typedef enum logic [1:0] {
    CBUS_FIXED = 2'd0,
    CBUS_INCR  = 2'd1,
    CBUS_WRAP  = 2'd2,
    CBUS_RSVD  = 2'd3
  } cbus_burst_e;

  typedef struct packed {
    logic               valid;
    logic               is_write;
    logic [2:0]         size;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_SW-1:0] strobe;
    logic [CBUS_DW-1:0] data;
    logic [7:0]         len;
    cbus_burst_e        burst;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_WRITE,
    ST_TURN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic            is_write_q, is_write_d;
  logic [2:0]      size_q, size_d;
  logic [AW-1:0]   start_q, start_d;
  logic [LW-1:0]   len_q, len_d;
  cbus_burst_e     burst_q, burst_d;
  cbus_resp_t      resp_q, resp_d;
  logic            stall_d;
  logic            mem_we;
  logic [AW-1:0]   waddr, raddr;
  logic [CBUS_DW-1:0] mem [DEPTH_WORDS];
  logic            unused_bits;

  // Word index of beat i; WRAP keeps the bits above the burst-length mask fixed.
  function automatic logic [AW-1:0] beat_idx(input logic [AW-1:0] start, input logic [LW-1:0] len,
                                             input cbus_burst_e burst, input logic [LW-1:0] beat);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc  = start + AW'(beat);
    mask = AW'(len);
    case (burst)
      CBUS_FIXED: beat_idx = start;
      CBUS_WRAP:  beat_idx = (start & ~mask) | (inc & mask);
      default:    beat_idx = inc;
    endcase
  endfunction

`ifdef CBUS_RAM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall_d = lfsr_d[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign stall_d = 1'b0;
`endif

  // Next state, latched request fields and the registered response for the coming cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    is_write_d = is_write_q;
    size_d     = size_q;
    start_d    = start_q;
    len_d      = len_q;
    burst_d    = burst_q;
    mem_we     = 1'b0;
    resp_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          size_d     = creq.size;
          start_d    = creq.addr[3 +: AW];
          len_d      = creq.len;
          burst_d    = creq.burst;
          beat_d     = '0;
          cnt_d      = CW'(LATENCY);
          if (LATENCY == 0) state_d = creq.is_write ? ST_WRITE : ST_READ;
          else              state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!creq.valid) begin
          state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = is_write_q ? ST_WRITE : ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (!creq.valid) begin
          state_d = ST_TURN;
        end else if (resp_q.ready) begin
          mem_we = (state_q == ST_WRITE);
          if (beat_q == len_q) state_d = ST_TURN;
          else                 beat_d  = beat_q + LW'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    raddr = beat_idx(start_d, len_d, burst_d, beat_d);
    if ((state_d == ST_READ || state_d == ST_WRITE) && !stall_d) begin
      resp_d.ready = 1'b1;
      resp_d.last  = (beat_d == len_d);
      if (state_d == ST_READ) resp_d.data = mem[raddr];
    end
  end

  assign waddr = beat_idx(start_q, len_q, burst_q, beat_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      is_write_q <= 1'b0;
      size_q     <= '0;
      start_q    <= '0;
      len_q      <= '0;
      burst_q    <= CBUS_FIXED;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      start_q    <= start_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      resp_q     <= resp_d;
    end
  end

  // Byte-masked write of the beat accepted on this edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < int'(CBUS_SW); k++) begin
        if (creq.strobe[k]) mem[waddr][8*k +: 8] <= creq.data[8*k +: 8];
      end
    end
  end

  assign cresp       = resp_q;
  assign unused_bits = ^{creq, size_q};
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Self-checking bench for cbus_ram_responder against an array-based memory and burst-address model.
module tb_cbus_ram_responder;
  import cbus_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned LAT   = 2;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  cbus_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .creq(creq), .cresp(cresp));

`ifdef CBUS_RAM_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_m <= 16'hACE1;
    else         lfsr_m <= {^(lfsr_m & 16'h002D), lfsr_m[15:1]};
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference addressing from the burst rules, in plain integer arithmetic.
  function automatic int beat_word(input int s, input int len, input cbus_burst_e b, input int i);
    int n;
    n = len + 1;
    case (b)
      CBUS_FIXED: return s;
      CBUS_WRAP:  return (s - (s % n)) + (((s % n) + i) % n);
      default:    return (s + i) % int'(DEPTH);
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 3) % DEPTH);
  endfunction

  task automatic model_write(input int s, input int len, input cbus_burst_e b,
                             input logic [63:0] wd[$], input logic [7:0] ws[$], input int nbeats);
    int w;
    for (int i = 0; i < nbeats; i++) begin
      w = beat_word(s, len, b, i);
      for (int k = 0; k < 8; k++) if (ws[i][k]) mem_m[w][8*k +: 8] = wd[i][8*k +: 8];
    end
  endtask

  // Bus master: issues one burst, collects read beats and timing observations.
  task automatic run_burst(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input cbus_burst_e burst, input logic [63:0] wdata[$],
                           input logic [7:0] wstrb[$], input bit hold,
                           output logic [63:0] rdata[$], output int first_lat, output int n_last,
                           output int last_beat, output int zero_err, output bit timeout);
    int nb, beats, k;
    cbus_resp_t r;
    nb = int'(len) + 1; beats = 0; k = 0;
    first_lat = -1; n_last = 0; last_beat = -1; zero_err = 0; rdata = {};
    @(posedge clk); #1;
    creq.valid = 1'b1; creq.is_write = wr; creq.size = MSIZE8; creq.addr = addr;
    creq.len = len; creq.burst = burst;
    creq.data = wr ? wdata[0] : 64'h0;
    creq.strobe = wr ? wstrb[0] : 8'h00;
    @(posedge clk);
    while (beats < nb && k < 600) begin
      @(negedge clk); k++; r = cresp;
      if (r.ready) begin
        if (first_lat < 0) first_lat = k;
        if (!wr) rdata.push_back(r.data);
        else if (r.data !== 64'h0) zero_err++;
        if (r.last) begin n_last++; last_beat = beats; end
        beats++;
      end else if (r.last !== 1'b0 || r.data !== 64'h0) begin
        zero_err++;
      end
      @(posedge clk); #1;
      if (wr && r.ready && beats < nb) begin creq.data = wdata[beats]; creq.strobe = wstrb[beats]; end
    end
    timeout = (beats < nb);
    if (!hold) creq.valid = 1'b0;
    @(negedge clk);
    if (cresp.ready !== 1'b0) zero_err++;
    if (hold) begin @(posedge clk); #1; creq.valid = 1'b0; end
  endtask

  task automatic test_reset();
    resetn = 1'b0; creq = '0;
    #12;
    n_checks++; if (cresp.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cresp.ready); end
    n_checks++; if (cresp.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", cresp.last); end
    n_checks++; if (cresp.data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", cresp.data); end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_preload();
    logic [63:0] wd[$], rd[$]; logic [7:0] ws[$];
    int fl, nl, lb, ze; bit to;
    for (int i = 0; i < 256; i++) begin wd.push_back(64'h1000 + 64'(i)); ws.push_back(8'hFF); end
    run_burst(1'b1, 32'h8000_0000, 8'd255, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    model_write(0, 255, CBUS_INCR, wd, ws, 256);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL preload_timeout: got %b want 0", to); end
    n_checks++; if (nl !== 1 || lb !== 255) begin n_fail++; $display("FAIL preload_last: got count %0d at %0d want 1 at 255", nl, lb); end
    n_checks++; if (ze !== 0) begin n_fail++; $display("FAIL preload_idle_zero: got %0d bad cycles want 0", ze); end
  endtask

  task automatic test_incr16();
    logic [63:0] wd[$], rd[$], got; logic [7:0] ws[$];
    int fl, nl, lb, ze; bit to;
    run_burst(1'b0, 32'h8000_0000, MLEN16, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
`ifdef CBUS_RAM_STALL_EN
    n_checks++; if (fl < int'(LAT) + 1) begin n_fail++; $display("FAIL incr16_latency: got %0d want >=%0d", fl, LAT + 1); end
`else
    n_checks++; if (fl !== int'(LAT) + 1) begin n_fail++; $display("FAIL incr16_latency: got %0d want %0d", fl, LAT + 1); end
`endif
    n_checks++; if (rd.size() !== 16) begin n_fail++; $display("FAIL incr16_beats: got %0d want 16", rd.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < rd.size()) ? rd[i] : 64'hx;
      n_checks++; if (got !== 64'h1000 + 64'(i)) begin n_fail++; $display("FAIL incr16_data[%0d]: got %h want %h", i, got, 64'h1000 + 64'(i)); end
    end
    n_checks++; if (nl !== 1 || lb !== 15) begin n_fail++; $display("FAIL incr16_last: got count %0d at %0d want 1 at 15", nl, lb); end
    n_checks++; if (ze !== 0 || to !== 1'b0) begin n_fail++; $display("FAIL incr16_zero: got %0d bad cycles timeout %b want 0 0", ze, to); end
  endtask

  task automatic test_wrap();
    logic [63:0] wd[$], rd[$], got, exp_w[4]; logic [7:0] ws[$];
    int fl, nl, lb, ze; bit to;
    exp_w[0] = 64'h1005; exp_w[1] = 64'h1006; exp_w[2] = 64'h1007; exp_w[3] = 64'h1004;
    run_burst(1'b0, 32'h8000_0028, MLEN4, CBUS_WRAP, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    for (int i = 0; i < 4; i++) begin
      got = (i < rd.size()) ? rd[i] : 64'hx;
      n_checks++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got, exp_w[i]); end
    end
    n_checks++; if (nl !== 1 || lb !== 3) begin n_fail++; $display("FAIL wrap_last: got count %0d at %0d want 1 at 3", nl, lb); end
  endtask

  task automatic test_write_strobe();
    logic [63:0] wd[$], rd[$], got; logic [7:0] ws[$];
    int fl, nl, lb, ze; bit to;
    wd = {64'hFFFF_FFFF_FFFF_FFFF}; ws = {8'hFF};
    run_burst(1'b1, 32'h8000_0040, MLEN1, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    model_write(8, 0, CBUS_INCR, wd, ws, 1);
    wd = {64'hAAAA_AAAA_BBBB_BBBB, 64'hAAAA_AAAA_BBBB_BBBB}; ws = {8'h0F, 8'h0F};
    run_burst(1'b1, 32'h8000_0040, MLEN2, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    model_write(8, 1, CBUS_INCR, wd, ws, 2);
    n_checks++; if (nl !== 1 || lb !== 1 || ze !== 0) begin n_fail++; $display("FAIL strobe_write_beats: got last %0d at %0d bad %0d want 1 at 1 bad 0", nl, lb, ze); end
    run_burst(1'b0, 32'h8000_0040, MLEN2, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    got = (rd.size() > 0) ? rd[0] : 64'hx;
    n_checks++; if (got !== 64'hFFFF_FFFF_BBBB_BBBB) begin n_fail++; $display("FAIL strobe_word8: got %h want ffffffffbbbbbbbb", got); end
    got = (rd.size() > 1) ? rd[1] : 64'hx;
    n_checks++; if (got !== 64'h0000_0000_BBBB_BBBB) begin n_fail++; $display("FAIL strobe_word9: got %h want 00000000bbbbbbbb", got); end
  endtask

  task automatic test_back_to_back_hold();
    logic [63:0] wd[$], rd[$], got; logic [7:0] ws[$];
    int fl, nl, lb, ze, extra; bit to;
    run_burst(1'b0, 32'h0000_00A0, MLEN4, CBUS_INCR, wd, ws, 1'b1, rd, fl, nl, lb, ze, to);
    n_checks++; if (rd.size() !== 4 || nl !== 1 || ze !== 0) begin n_fail++; $display("FAIL hold_first: got beats %0d last %0d bad %0d want 4 1 0", rd.size(), nl, ze); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (cresp.ready !== 1'b0) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL hold_reserved: got %0d ready cycles want 0", extra); end
    run_burst(1'b0, 32'h0000_00A0, MLEN4, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
`ifndef CBUS_RAM_STALL_EN
    n_checks++; if (fl !== int'(LAT) + 1) begin n_fail++; $display("FAIL hold_second_latency: got %0d want %0d", fl, LAT + 1); end
`endif
    for (int i = 0; i < 4; i++) begin
      got = (i < rd.size()) ? rd[i] : 64'hx;
      n_checks++; if (got !== mem_m[20 + i]) begin n_fail++; $display("FAIL hold_second_data[%0d]: got %h want %h", i, got, mem_m[20 + i]); end
    end
  endtask

  task automatic test_alias();
    logic [63:0] wd[$], rd[$], got; logic [7:0] ws[$];
    int fl, nl, lb, ze, w; bit to;
    for (int i = 0; i < 4; i++) begin wd.push_back({$urandom, $urandom}); ws.push_back(8'hFF); end
    run_burst(1'b1, 32'h0001_7FF0, MLEN4, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    model_write(4094, 3, CBUS_INCR, wd, ws, 4);
    run_burst(1'b0, 32'hFFFF_FFF5, MLEN4, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    for (int i = 0; i < 4; i++) begin
      w = (4094 + i) % int'(DEPTH);
      got = (i < rd.size()) ? rd[i] : 64'hx;
      n_checks++; if (got !== mem_m[w]) begin n_fail++; $display("FAIL alias_data[%0d]: got %h want %h", i, got, mem_m[w]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] wd[$], rd[$], got; logic [7:0] ws[$];
    int fl, nl, lb, ze, len, s, w; bit to, wr; cbus_burst_e b; logic [31:0] addr;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      b  = cbus_burst_e'($urandom_range(0, 3));
      if (b == CBUS_WRAP) len = (1 << $urandom_range(0, 4)) - 1;
      else                len = int'($urandom_range(0, 15));
      s = int'($urandom_range(0, 239));
      addr = ($urandom & 32'hFFFF_8000) | (32'(s) << 3) | 32'($urandom_range(0, 7));
      wd = {}; ws = {};
      for (int i = 0; i <= len; i++) begin wd.push_back({$urandom, $urandom}); ws.push_back(8'($urandom_range(0, 255))); end
      run_burst(wr, addr, 8'(len), b, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
      n_checks++; if (to !== 1'b0 || nl !== 1 || lb !== len || ze !== 0) begin
        n_fail++; $display("FAIL rand%0d_handshake: got timeout %b last %0d at %0d bad %0d want 0 1 at %0d 0", t, to, nl, lb, ze, len);
      end
      if (wr) begin
        model_write(word_of(addr), len, b, wd, ws, len + 1);
      end else begin
        for (int i = 0; i <= len; i++) begin
          w = beat_word(word_of(addr), len, b, i);
          got = (i < rd.size()) ? rd[i] : 64'hx;
          n_checks++; if (got !== mem_m[w]) begin n_fail++; $display("FAIL rand%0d_data[%0d]: got %h want %h", t, i, got, mem_m[w]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] wd[$], rd[$], got; logic [7:0] ws[$];
    int fl, nl, lb, ze, beats, k; bit to, hit;
    for (int i = 0; i < 16; i++) begin wd.push_back({$urandom, $urandom} ^ mem_m[i] ^ 64'h1); ws.push_back(8'hFF); end
    @(posedge clk); #1;
    creq = '0; creq.valid = 1'b1; creq.is_write = 1'b1; creq.size = MSIZE8; creq.addr = 32'h8000_0000;
    creq.len = MLEN16; creq.burst = CBUS_INCR; creq.data = wd[0]; creq.strobe = ws[0];
    @(posedge clk);
    beats = 0; k = 0; hit = 1'b0;
    while (!hit && k < 100) begin
      @(negedge clk); k++;
      if (cresp.ready && beats == 3) begin
        hit = 1'b1;
      end else begin
        if (cresp.ready) beats++;
        @(posedge clk); #1;
        creq.data = wd[beats]; creq.strobe = ws[beats];
      end
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_beat3: got %b want 1", hit); end
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (cresp !== '0) begin n_fail++; $display("FAIL rstmid_async_clear: got %h want 0", cresp); end
    creq.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    model_write(0, 15, CBUS_INCR, wd, ws, 3);
    run_burst(1'b0, 32'h8000_0000, MLEN16, CBUS_INCR, wd, ws, 1'b0, rd, fl, nl, lb, ze, to);
    n_checks++; if (to !== 1'b0 || nl !== 1 || lb !== 15) begin n_fail++; $display("FAIL rstmid_next_burst: got timeout %b last %0d at %0d want 0 1 at 15", to, nl, lb); end
    for (int i = 0; i < 16; i++) begin
      got = (i < rd.size()) ? rd[i] : 64'hx;
      n_checks++; if (got !== mem_m[i]) begin n_fail++; $display("FAIL rstmid_word[%0d]: got %h want %h", i, got, mem_m[i]); end
    end
  endtask

`ifdef CBUS_RAM_STALL_EN
  task automatic test_stall();
    int k, beats, nl, lb;
    cbus_resp_t r;
    @(posedge clk); #1;
    creq = '0; creq.valid = 1'b1; creq.size = MSIZE8; creq.addr = 32'h8000_0080;
    creq.len = MLEN8; creq.burst = CBUS_INCR;
    @(posedge clk);
    k = 0; beats = 0; nl = 0; lb = -1;
    while (beats < 8 && k < 300) begin
      @(negedge clk); k++; r = cresp;
      if (k > int'(LAT)) begin
        n_checks++; if (r.ready !== ~lfsr_m[0]) begin n_fail++; $display("FAIL stall_gap_c%0d: got ready %b want %b", k, r.ready, ~lfsr_m[0]); end
      end
      if (r.ready) begin
        n_checks++; if (r.data !== mem_m[16 + beats]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", beats, r.data, mem_m[16 + beats]); end
        if (r.last) begin nl++; lb = beats; end
        beats++;
      end
      @(posedge clk); #1;
    end
    creq.valid = 1'b0;
    n_checks++; if (beats !== 8 || nl !== 1 || lb !== 7) begin n_fail++; $display("FAIL stall_summary: got beats %0d last %0d at %0d want 8 1 at 7", beats, nl, lb); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_preload();
    test_incr16();
    test_wrap();
    test_write_strobe();
    test_back_to_back_hold();
    test_alias();
    test_random();
    test_reset_mid_burst();
`ifdef CBUS_RAM_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cbus_ram_responder.md
# cbus_ram_responder

Synthesizable on-chip memory that acts as the responder (slave) end of the simplified burst cache bus. It accepts `cbus_req_t` transactions from a cache or arbiter master and returns `cbus_resp_t` beats. It stands in for the AXI memory path in simulation and small FPGA builds, so caches can be exercised without the full AXI bridge.

## Interface
- `DEPTH_WORDS`, default 4096: number of 64-bit words, power of two.
- `LATENCY`, default 2: idle cycles between request acceptance and the first beat (0–15).
- `clk` input, 1: clock; all state changes on rising edge.
- `resetn` input, 1: one clock; reset is asynchronous and active-low.
- `creq` input, `cbus_req_t`: master request (valid, is_write, size, addr, strobe, data, len, burst).
- `cresp` output, `cbus_resp_t`: ready, last, data.

## Operation
- Word index = `addr[3 +: log2(DEPTH_WORDS)]`; upper address bits are ignored, which aliases modulo the depth. Bits `addr[2:0]` are ignored: every beat is a full aligned 64-bit word.
- `size` is latched but does not affect addressing. The beat stride is always 8 bytes, because caches issue MSIZE8 bursts.
- Beat count = `len + 1` (1–256). Beat index i runs 0..len.
- Burst addressing:
  - FIXED: every beat uses the start word.
  - INCR: start + i, wrapping modulo depth.
  - WRAP: the low `log2(len+1)` index bits increment modulo `len+1`; higher bits stay fixed.
  - RESERVED: treated as INCR.
- Reads: `cresp.data` = the memory word at the beat address.
- Writes: on a beat where `cresp.ready=1`, byte k of the word is written from `creq.data` byte k when `creq.strobe[k]=1`. Other bytes are unchanged.
- Memory contents are not reset.
- FSM states: IDLE, WAIT, READ, WRITE, TURN.
  - IDLE to WAIT: `creq.valid=1`. All request fields except data/strobe are latched, and the wait counter is loaded with LATENCY. With LATENCY=0, go straight to READ or WRITE.
  - WAIT: counter decrements each cycle. At 0, go to READ if is_write=0, otherwise WRITE.
  - READ/WRITE: one beat per cycle. The beat counter increments on each ready. On the beat with index = len, `last=1`, then go to TURN.
  - TURN: one cycle with ready=0, then IDLE. The master must drop valid in this cycle, so a held valid is never re-served as a new request.
- Protocol rules:
  - The master holds all fields except data/strobe stable while valid=1.
  - For writes, the master advances data/strobe on the edge where ready=1.
  - If valid falls in WAIT, READ or WRITE, the burst aborts: go to TURN with no further writes.

## Timing
- Reset (async assert) values:
  - `cresp.ready=0`, `cresp.last=0`, `cresp.data=0`.
  - FSM = IDLE; all counters 0.
- Reset has priority mid-burst; an interrupted write keeps only the beats already committed.
- All `cresp` fields are registered; no combinational path from `creq` to `cresp`.
- Accept edge T0, meaning IDLE with valid=1 sampled.
  - First beat is valid during cycle T0+1+LATENCY.
  - Following beats are back-to-back, one per cycle, in stall-free builds.
- `last` is high only together with ready, on the final beat.
- `data` = 0 whenever ready=0 and during write beats.
- Minimum spacing between accepts of consecutive transactions: beats + LATENCY + 2 cycles.

## Configuration
- `CBUS_RAM_STALL_EN`
  - Defined: a 16-bit LFSR (seed 16'hACE1, reset to seed) advances every cycle. When LFSR bit0=1 in READ/WRITE, that cycle is a stall: ready=0, no beat, no counter advance. This exercises master back-pressure handling.
  - Undefined: no LFSR is present, and beats are strictly back-to-back.

## Test plan
- Preload words 0..15 with `0x1000+i`; INCR read, addr `0x8000_0000`, len MLEN16, LATENCY=2 → first ready at T0+3; data `0x1000..0x100F` on consecutive cycles; last only on the 16th beat.
- WRAP read, addr `0x8000_0028` (word 5), len MLEN4 → data order: words 5, 6, 7, 4.
- INCR write, len MLEN2, strobe `8'h0F`, data `0xAAAA_AAAA_BBBB_BBBB` to word 8, which holds `0xFFFF…` → then read back word 8 = `0xFFFF_FFFF_BBBB_BBBB`.
- Read with valid held through TURN, then dropped, then raised again → exactly one burst served per valid assertion; the second accept occurs no earlier than TURN+1.
- Assert resetn=0 at beat 3 of a 16-beat write → `cresp` is zero immediately (asynchronously); words 0–2 written, word 3 onward unchanged; next request is served normally.
- With `CBUS_RAM_STALL_EN` defined, INCR read len MLEN8 → 8 beats with correct data in order, gaps matching the LFSR sequence, exactly one last.
